// File: rtl/aes_decipher_block_par.sv
// ---------------------------------------------------------------------------
// aes_decipher_block_par
//
// Iterative AES inverse-cipher datapath for 128/192/256-bit keys. One round
// is processed as a burst of InvSubBytes cycles (SBOX) followed by a single
// MAIN cycle that applies AddRoundKey, InvMixColumns and InvShiftRows. The
// NUM_SBOX parameter selects how many 32-bit columns pass through an inverse
// S-box word per cycle (1, 2 or 4). This trades area against latency.
//
// The round key is not stored here. The key memory returns round_key
// combinationally for the index presented on 'round'.
//
// Ports:
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   next          start request, only honoured while idle
//   abort         synchronous abort, wipes the datapath state
//   keylen        key size: 00=128, 01=192, 10=256, 11=reserved (ignored)
//   round         round-key index presented to the key memory
//   round_key     round key for index 'round', valid in the same cycle
//   block         ciphertext, sampled in the INIT cycle
//   new_block     plaintext result or intermediate state
//   ready         high when idle and able to accept next
//   result_valid  one-cycle pulse when new_block holds a finished plaintext
// ---------------------------------------------------------------------------
module aes_decipher_block_par #(
    parameter int NUM_SBOX = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         next,
    input  logic         abort,
    input  logic [1:0]   keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready,
    output logic         result_valid
);

    localparam int SUBST_CYCLES = 4 / NUM_SBOX;
    localparam int CNT_W        = (SUBST_CYCLES > 1) ? $clog2(SUBST_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SUBST_CYCLES - 1);

    if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4) begin : g_num_sbox_check
        $error("aes_decipher_block_par: NUM_SBOX must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, INIT, SBOX, MAIN} state_t;

    state_t             state_q, state_d;
    logic [3:0]         round_q, round_d;
    logic [127:0]       block_q, block_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         keylen_q, keylen_d;
    logic               ready_q, ready_d;
    logic               result_valid_q, result_valid_d;

    logic [31:0]        sub_words [4];
    logic [127:0]       sub_state;

    // GF(2^8) multiply, reduction polynomial 0x11b.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 via an addition chain; 0 maps to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x3, x7, x15, x31, x63, x127;
        x3   = gf_mul(gf_mul(x, x), x);
        x7   = gf_mul(gf_mul(x3, x3), x);
        x15  = gf_mul(gf_mul(x7, x7), x);
        x31  = gf_mul(gf_mul(x15, x15), x);
        x63  = gf_mul(gf_mul(x31, x31), x);
        x127 = gf_mul(gf_mul(x63, x63), x);
        return gf_mul(x127, x127);
    endfunction

    // Inverse S-box: undo the affine map first, then invert in GF(2^8).
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] t;
        t = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    function automatic logic [31:0] inv_sub_word(input logic [31:0] w);
        return {inv_sbox(w[31:24]), inv_sbox(w[23:16]), inv_sbox(w[15:8]), inv_sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        a0 = w[31:24];
        a1 = w[23:16];
        a2 = w[15:8];
        a3 = w[7:0];
        return {gf_mul(a0, 8'd14) ^ gf_mul(a1, 8'd11) ^ gf_mul(a2, 8'd13) ^ gf_mul(a3, 8'd9),
                gf_mul(a0, 8'd9)  ^ gf_mul(a1, 8'd14) ^ gf_mul(a2, 8'd11) ^ gf_mul(a3, 8'd13),
                gf_mul(a0, 8'd13) ^ gf_mul(a1, 8'd9)  ^ gf_mul(a2, 8'd14) ^ gf_mul(a3, 8'd11),
                gf_mul(a0, 8'd11) ^ gf_mul(a1, 8'd13) ^ gf_mul(a2, 8'd9)  ^ gf_mul(a3, 8'd14)};
    endfunction

    function automatic logic [127:0] inv_mix_cols(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) r[127 - 32*c -: 32] = inv_mix_col(s[127 - 32*c -: 32]);
        return r;
    endfunction

    // Row r of the state is rotated right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 32*c - 8*row -: 8] = s[127 - 32*((c - row + 4) % 4) - 8*row -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] rounds_for(input logic [1:0] kl);
        case (kl)
            2'b00:   return 4'd10;
            2'b01:   return 4'd12;
            default: return 4'd14;
        endcase
    endfunction

    // Column handled by S-box instance j in the current substitution cycle.
    function automatic logic [1:0] sel_idx(input logic [CNT_W-1:0] cnt, input int j);
        return 2'(int'(cnt) * NUM_SBOX + j);
    endfunction

    // NUM_SBOX inverse S-box words; the columns not selected this cycle pass through.
    always_comb begin
        for (int i = 0; i < 4; i++) sub_words[i] = block_q[127 - 32*i -: 32];
        for (int j = 0; j < NUM_SBOX; j++) begin
            sub_words[sel_idx(cnt_q, j)] =
                inv_sub_word(block_q[127 - 32*int'(sel_idx(cnt_q, j)) -: 32]);
        end
    end

    assign sub_state = {sub_words[0], sub_words[1], sub_words[2], sub_words[3]};

    // Next-state and datapath update. Abort overrides every state, including IDLE.
    always_comb begin
        state_d        = state_q;
        round_d        = round_q;
        block_d        = block_q;
        cnt_d          = cnt_q;
        keylen_d       = keylen_q;
        ready_d        = ready_q;
        result_valid_d = 1'b0;

        if (abort) begin
            state_d = IDLE;
            ready_d = 1'b1;
            round_d = 4'd0;
            block_d = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (next && keylen != 2'b11) begin
                        keylen_d = keylen;
                        round_d  = rounds_for(keylen);
                        ready_d  = 1'b0;
                        state_d  = INIT;
                    end
                end
                INIT: begin
                    // round already holds N; it is re-derived from the latched key
                    // size so the key-memory index depends only on the latched value.
                    round_d = rounds_for(keylen_q);
                    block_d = inv_shift_rows(block ^ round_key);
                    cnt_d   = '0;
                    state_d = SBOX;
                end
                SBOX: begin
                    block_d = sub_state;
                    if (cnt_q == CNT_LAST) begin
                        round_d = round_q - 4'd1;
                        state_d = MAIN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                MAIN: begin
                    if (round_q != 4'd0) begin
                        block_d = inv_shift_rows(inv_mix_cols(block_q ^ round_key));
                        cnt_d   = '0;
                        state_d = SBOX;
                    end else begin
                        block_d        = block_q ^ round_key;
                        ready_d        = 1'b1;
                        result_valid_d = 1'b1;
                        state_d        = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            round_q        <= 4'd0;
            block_q        <= '0;
            cnt_q          <= '0;
            keylen_q       <= 2'b00;
            ready_q        <= 1'b1;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            round_q        <= round_d;
            block_q        <= block_d;
            cnt_q          <= cnt_d;
            keylen_q       <= keylen_d;
            ready_q        <= ready_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign round        = round_q;
    assign new_block    = block_q;
    assign ready        = ready_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_aes_decipher_block_par.sv
// ---------------------------------------------------------------------------
// tb_aes_decipher_block_par
//
// Drives three instances (NUM_SBOX = 1, 2, 4) in lock-step from shared inputs.
// Each instance gets its own round key, taken from a key schedule computed in
// the bench for the round index that instance presents. Expected plaintexts
// come from the FIPS-197 appendix C vectors. For random runs, a forward-cipher
// model encrypts a random plaintext, and the DUTs must recover it.
// ---------------------------------------------------------------------------
module tb_aes_decipher_block_par;

    localparam int NI = 3;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         next;
    logic         abort;
    logic [1:0]   keylen;
    logic [127:0] block;

    logic [3:0]   round_w  [NI];
    logic [127:0] rkey_w   [NI];
    logic [127:0] nb_w     [NI];
    logic         ready_w  [NI];
    logic         rv_w     [NI];

    logic [127:0] rk [16];
    logic [7:0]   fsbox [256];

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] PT_C = 128'h00112233445566778899aabbccddeeff;

    always #5 clk = ~clk;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        assign rkey_w[k] = rk[round_w[k]];
        aes_decipher_block_par #(.NUM_SBOX(1 << k)) u_dut (
            .clk          (clk),
            .reset_n      (reset_n),
            .next         (next),
            .abort        (abort),
            .keylen       (keylen),
            .round        (round_w[k]),
            .round_key    (rkey_w[k]),
            .block        (block),
            .new_block    (nb_w[k]),
            .ready        (ready_w[k]),
            .result_valid (rv_w[k])
        );
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return gmul(a, 8'h02);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {fsbox[w[31:24]], fsbox[w[23:16]], fsbox[w[15:8]], fsbox[w[7:0]]};
    endfunction

    // Forward S-box from its definition: brute-force inverse, then affine map.
    task automatic buildSbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            fsbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Key expansion; key occupies the top Nk words of the 256-bit argument.
    task automatic loadKey(input logic [255:0] key, input logic [1:0] kl);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nk;
        int nr;
        nk = (kl == 2'b00) ? 4 : (kl == 2'b01) ? 6 : 8;
        nr = nk + 6;
        for (int i = 0; i < 60; i++) w[i] = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        rc = 8'h01;
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++) rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
    endtask

    // Textbook forward cipher over a byte array; byte n is bits [127-8n -: 8].
    function automatic logic [127:0] encrypt(input logic [127:0] pt, input int nr);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] out;
        for (int n = 0; n < 16; n++) s[n] = pt[127 - 8*n -: 8] ^ rk[0][127 - 8*n -: 8];
        for (int rd = 1; rd <= nr; rd++) begin
            for (int n = 0; n < 16; n++) s[n] = fsbox[s[n]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[4*c + row] = s[4*((c + row) % 4) + row];
            s = t;
            if (rd != nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int n = 0; n < 16; n++) s[n] = s[n] ^ rk[rd][127 - 8*n -: 8];
        end
        out = '0;
        for (int n = 0; n < 16; n++) out[127 - 8*n -: 8] = s[n];
        return out;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkIdleCleared(input string tag);
        for (int k = 0; k < NI; k++) begin
            checkOutput($sformatf("%s ready[%0d]", tag, k), 128'(ready_w[k]), 128'(1));
            checkOutput($sformatf("%s round[%0d]", tag, k), 128'(round_w[k]), 128'(0));
            checkOutput($sformatf("%s new_block[%0d]", tag, k), nb_w[k], 128'(0));
            checkOutput($sformatf("%s result_valid[%0d]", tag, k), 128'(rv_w[k]), 128'(0));
        end
    endtask

    // One operation on all instances. abort_at / reset_at name the cycle after
    // acceptance at which the run is cut short (0 = never).
    task automatic applyStimulus(input logic [1:0] kl, input logic [127:0] blk, input logic [127:0] exp_pt,
                                 input int abort_at, input int reset_at, input bit hold_next,
                                 input bit toggle_kl, input string tag);
        int          lat      [NI];
        int          pulses   [NI];
        bit          done     [NI];
        logic [127:0] cap     [NI];
        int          seq_err  [NI];
        logic [3:0]  prev_rnd [NI];
        bit          was_done;
        bit          stopped;
        int          n_rounds;
        int          max_lat;
        n_rounds = 10 + 2 * int'(kl);
        max_lat  = 1 + n_rounds * 5;
        stopped  = 1'b0;
        keylen   = kl;
        block    = blk;
        next     = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < NI; k++) begin
            checkOutput($sformatf("%s accept ready[%0d]", tag, k), 128'(ready_w[k]), 128'(0));
            checkOutput($sformatf("%s accept round[%0d]", tag, k), 128'(round_w[k]), 128'(n_rounds));
            lat[k] = 0; pulses[k] = 0; done[k] = 1'b0; cap[k] = '0; seq_err[k] = 0;
            prev_rnd[k] = round_w[k];
        end
        if (!hold_next) next = 1'b0;
        for (int cyc = 1; cyc <= max_lat + 2; cyc++) begin
            if (cyc == 2) block = ~blk;
            if (toggle_kl) keylen = 2'($urandom_range(0, 3));
            if (cyc == abort_at) abort = 1'b1;
            @(posedge clk); #1;
            if (cyc == abort_at) begin
                abort = 1'b0;
                checkIdleCleared($sformatf("%s abort@%0d", tag, cyc));
                for (int k = 0; k < NI; k++)
                    checkOutput($sformatf("%s abort no earlier pulse[%0d]", tag, k), 128'(pulses[k]), 128'(0));
                stopped = 1'b1;
                break;
            end
            for (int k = 0; k < NI; k++) begin
                was_done = done[k];
                if (rv_w[k] && !was_done) begin
                    pulses[k]++;
                    cap[k] = nb_w[k];
                end
                if (!was_done && ready_w[k]) begin
                    done[k] = 1'b1;
                    lat[k]  = cyc;
                end else if (!was_done && round_w[k] != prev_rnd[k]) begin
                    if (round_w[k] != prev_rnd[k] - 4'd1) seq_err[k]++;
                    prev_rnd[k] = round_w[k];
                end
                if (was_done && cyc == lat[k] + 1) begin
                    checkOutput($sformatf("%s pulse width[%0d]", tag, k), 128'(rv_w[k]), 128'(0));
                    checkOutput($sformatf("%s ready after done[%0d]", tag, k), 128'(ready_w[k]),
                                hold_next ? 128'(0) : 128'(1));
                end
            end
            if (cyc == reset_at) begin
                #2 reset_n = 1'b0;
                #1 checkIdleCleared($sformatf("%s async reset", tag));
                #2 reset_n = 1'b1;
                stopped = 1'b1;
                break;
            end
        end
        if (!stopped) begin
            for (int k = 0; k < NI; k++) begin
                checkOutput($sformatf("%s completed[%0d]", tag, k), 128'(done[k]), 128'(1));
                checkOutput($sformatf("%s latency[%0d]", tag, k), 128'(lat[k]),
                            128'(1 + n_rounds * (4 / (1 << k) + 1)));
                checkOutput($sformatf("%s pulses[%0d]", tag, k), 128'(pulses[k]), 128'(1));
                checkOutput($sformatf("%s plaintext[%0d]", tag, k), cap[k], exp_pt);
                checkOutput($sformatf("%s round seq[%0d]", tag, k), 128'(seq_err[k]), 128'(0));
                checkOutput($sformatf("%s final round[%0d]", tag, k), 128'(prev_rnd[k]), 128'(0));
                if (!hold_next)
                    checkOutput($sformatf("%s held result[%0d]", tag, k), nb_w[k], exp_pt);
            end
        end
        next = 1'b0;
        if (hold_next) begin
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
        end
        keylen = kl;
    endtask

    initial begin
        logic [255:0] key;
        logic [127:0] pt;
        logic [1:0]   kl;
        buildSbox();
        reset_n = 1'b0;
        next    = 1'b0;
        abort   = 1'b0;
        keylen  = 2'b00;
        block   = '0;
        repeat (2) @(posedge clk);
        #1;
        checkIdleCleared("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;

        loadKey({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 2'b00);
        applyStimulus(2'b00, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT_C, 0, 0, 0, 0, "C1");

        loadKey({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 2'b01);
        applyStimulus(2'b01, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, PT_C, 0, 0, 0, 0, "C2");

        loadKey(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 2'b10);
        applyStimulus(2'b10, 128'h8ea2b7ca516745bfeafc49904b496089, PT_C, 0, 0, 0, 0, "C3");

        // Abort in IDLE together with next: result cleared, request dropped.
        keylen = 2'b00; next = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        next = 1'b0; abort = 1'b0;
        checkIdleCleared("idle abort");

        // Reserved key length: request ignored.
        keylen = 2'b11; next = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        next = 1'b0;
        for (int k = 0; k < NI; k++) begin
            checkOutput($sformatf("keylen11 ready[%0d]", k), 128'(ready_w[k]), 128'(1));
            checkOutput($sformatf("keylen11 round[%0d]", k), 128'(round_w[k]), 128'(0));
        end

        loadKey({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 2'b00);
        applyStimulus(2'b00, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT_C, 20, 0, 0, 0, "C1 abort20");
        applyStimulus(2'b00, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT_C, 0, 0, 0, 0, "C1 after abort");
        applyStimulus(2'b00, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT_C, 21, 0, 0, 0, "C1 abort21");
        applyStimulus(2'b00, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT_C, 0, 0, 1, 0, "C1 hold next");

        loadKey({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 2'b01);
        applyStimulus(2'b01, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, PT_C, 0, 0, 0, 1, "C2 keylen toggle");

        loadKey(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 2'b10);
        applyStimulus(2'b10, 128'h8ea2b7ca516745bfeafc49904b496089, PT_C, 0, 7, 0, 0, "C3 reset");
        applyStimulus(2'b10, 128'h8ea2b7ca516745bfeafc49904b496089, PT_C, 0, 0, 0, 0, "C3 after reset");

        for (int i = 0; i < 3; i++) begin
            key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            kl  = 2'($urandom_range(0, 2));
            loadKey(key, kl);
            applyStimulus(kl, encrypt(pt, 10 + 2 * int'(kl)), pt, 0, 0, 0, 0, $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
